lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Pipeline MEM stage of the RV32I core. Sits directly upstream of the `memory` block.
- Accepts load/store ops from EX and drives the dmem request port of `memory`.
- Absorbs the `dmem_wait` stall that `memory` raises for split (unaligned) accesses.
- Sign/zero-extends returned load data and hands a registered result to WB.
- Sustains one aligned access per cycle, pipelined: issue in cycle N, data on `dmem_read_data` in N+1.

Parameters:
- ADDR_W, 32, address width; dmem_address width equals ADDR_W.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- ex_valid  in  1  EX presents an op this cycle.
- ex_load  in  1  op is a load.
- ex_store  in  1  op is a store.
- ex_funct3  in  3  RISC-V funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU).
- ex_address  in  32  effective address.
- ex_store_data  in  32  rs2 value.
- ex_rd  in  5  destination register.
- ex_ready  out  1  stage can accept an op this cycle.
- dmem_address  out  32  to memory.
- dmem_enable  out  1  to memory.
- dmem_write_data  out  32  to memory.
- dmem_write_enable  out  1  to memory.
- dmem_write_mode  out  3  to memory.
- dmem_read_enable  out  1  to memory.
- dmem_read_mode  out  3  to memory.
- dmem_read_data  in  32  from memory; zero-extended, LSB-justified.
- dmem_wait  in  1  from memory; split access in progress.
- wb_valid  out  1  one-cycle pulse per completed op.
- wb_we  out  1  write rd (load, rd!=0, no error).
- wb_rd  out  5  destination register.
- wb_data  out  32  extended load value; 0 for stores.
- wb_error  out  1  illegal funct3 (funct3[1:0]==3).

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE; in-flight regs and all wb_* cleared to 0.
  - While reset_n=0, all dmem_* outputs are forced 0 and ex_ready=0.
  - Reset mid-access (including during dmem_wait) drops the access; memory resets on the same edge.
- States:
  - IDLE: nothing in flight.
  - ACCESS: a request was issued last cycle; its response is due this cycle.
- Issue rule (IDLE, or ACCESS with dmem_wait=0):
  - Condition: ex_valid & ex_ready & (ex_load | ex_store).
  - Drive dmem_* combinationally from ex_*: mode=ex_funct3, read_enable=ex_load, write_enable=ex_store & ~ex_load, enable=read_enable|write_enable.
  - Capture op into in-flight reg; next state=ACCESS.
- Load precedence: ex_load & ex_store together executes as a load only.
- Illegal funct3 (funct3[1:0]==3): no memory access (all dmem enables 0). Op still enters ACCESS and completes with wb_error=1, wb_we=0, wb_data=0.
- ex_valid with neither load nor store: ignored, no wb pulse.
- ACCESS with dmem_wait=1:
  - ex_ready=0; state stays ACCESS.
  - dmem_* outputs re-driven from the in-flight reg, bit-identical to the issue cycle, because memory samples write_mode/data during its wait cycle.
- ACCESS with dmem_wait=0:
  - Response completes. Next posedge: wb_valid=1, wb_rd, wb_we, wb_error; wb_data extended from dmem_read_data:
    - f3=0: sign-extend bit7.
    - f3=1: sign-extend bit15.
    - f3=2: pass through.
    - f3=4/5: zero-extend.
  - Same cycle, a new op may issue (back-to-back).
  - If no new op issues, next state=IDLE.
- ex_ready = reset_n & ~(state==ACCESS & dmem_wait).
- Latency from issue to wb_valid: 2 cycles aligned, 3 cycles unaligned (LH@+3, LW/SW@+1..+3).
- dmem_wait seen in IDLE: ignored.
- wb_valid is a single-cycle pulse; wb_* other than wb_valid hold their last value.

Test Plan:
- Reset, then LW 0x8000_0000 (mem=0xDEADBEEF) -> wb_valid at issue+2, wb_data=0xDEADBEEF, wb_we=1, wb_rd=ex_rd.
- LB 0x8000_0001 with byte 0x80, then LBU same address -> wb_data 0xFFFFFF80, then 0x00000080. LH of 0x8001 -> 0xFFFF8001.
- LW 0x8000_0002 (unaligned) -> ex_ready=0 for exactly 1 cycle, dmem_* stable across the wait, wb_data merged correctly at issue+3. Back-to-back LW 0x8000_0004 issues in the cycle wait drops.
- SW 0x8000_0003 data 0x11223344, then LW 0x8000_0000 and LW 0x8000_0004 -> 0x44xxxxxx and 0xxx112233. Store wb_valid=1, wb_we=0, wb_data=0.
- funct3=3 load with rd=5 -> dmem_enable stays 0, wb_valid=1, wb_error=1, wb_we=0.
- 4 back-to-back aligned LWs -> 4 wb_valid pulses on consecutive cycles. reset_n low during an unaligned wait -> no wb_valid, all outputs 0, IDLE after release.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/response port between the MEM stage and the memory block.
interface lsu_mem_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
);
    logic [ADDR_W-1:0] dmem_address;
    logic              dmem_enable;
    logic [XLEN-1:0]   dmem_write_data;
    logic              dmem_write_enable;
    logic [2:0]        dmem_write_mode;
    logic              dmem_read_enable;
    logic [2:0]        dmem_read_mode;
    logic [XLEN-1:0]   dmem_read_data;
    logic              dmem_wait;

    modport master (
        output dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
               dmem_write_mode, dmem_read_enable, dmem_read_mode,
        input  dmem_read_data, dmem_wait
    );

    modport slave (
        input  dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
               dmem_write_mode, dmem_read_enable, dmem_read_mode,
        output dmem_read_data, dmem_wait
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I MEM stage: issues loads/stores to data memory, holds the request steady
// through split-access stalls, and hands a registered, extended result to WB.
module lsu_mem_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ex_valid,
    input  logic                ex_load,
    input  logic                ex_store,
    input  logic [2:0]          ex_funct3,
    input  logic [ADDR_W-1:0]   ex_address,
    input  logic [XLEN-1:0]     ex_store_data,
    input  logic [4:0]          ex_rd,
    output logic                ex_ready,
    lsu_mem_stage_if.master     dmem,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                wb_error
);
    localparam int unsigned RD_W = 5;
    localparam int unsigned F3_W = 3;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] inf_address;
    logic [XLEN-1:0]   inf_write_data;
    logic [F3_W-1:0]   inf_funct3;
    logic [RD_W-1:0]   inf_rd;
    logic              inf_read;
    logic              inf_write;
    logic              inf_error;

    logic ex_illegal, stalled, issue, issue_read, issue_write, complete;

    assign ex_illegal  = (ex_funct3[1:0] == 2'd3);
    assign stalled     = (state == ACCESS) && dmem.dmem_wait;
    assign ex_ready    = reset_n && !stalled;
    assign issue       = ex_valid && ex_ready && (ex_load || ex_store);
    // A load wins when both load and store are flagged.
    assign issue_read  = ex_load && !ex_illegal;
    assign issue_write = ex_store && !ex_load && !ex_illegal;
    assign complete    = (state == ACCESS) && !dmem.dmem_wait;

    function automatic logic [XLEN-1:0] extend(input logic [F3_W-1:0] f3,
                                                input logic [XLEN-1:0] d);
        case (f3)
            3'd0:    return {{(XLEN-8){d[7]}}, d[7:0]};
            3'd1:    return {{(XLEN-16){d[15]}}, d[15:0]};
            3'd4:    return {{(XLEN-8){1'b0}}, d[7:0]};
            3'd5:    return {{(XLEN-16){1'b0}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Memory samples the request again during its wait cycle, so re-drive it unchanged.
    always_comb begin
        state_next             = state;
        dmem.dmem_address      = '0;
        dmem.dmem_enable       = 1'b0;
        dmem.dmem_write_data   = '0;
        dmem.dmem_write_enable = 1'b0;
        dmem.dmem_write_mode   = '0;
        dmem.dmem_read_enable  = 1'b0;
        dmem.dmem_read_mode    = '0;
        if (!reset_n) begin
            state_next = IDLE;
        end else if (stalled) begin
            dmem.dmem_address      = inf_address;
            dmem.dmem_write_data   = inf_write_data;
            dmem.dmem_write_mode   = inf_funct3;
            dmem.dmem_read_mode    = inf_funct3;
            dmem.dmem_read_enable  = inf_read;
            dmem.dmem_write_enable = inf_write;
            dmem.dmem_enable       = inf_read || inf_write;
            state_next             = ACCESS;
        end else if (issue) begin
            dmem.dmem_address      = ex_address;
            dmem.dmem_write_data   = ex_store_data;
            dmem.dmem_write_mode   = ex_funct3;
            dmem.dmem_read_mode    = ex_funct3;
            dmem.dmem_read_enable  = issue_read;
            dmem.dmem_write_enable = issue_write;
            dmem.dmem_enable       = issue_read || issue_write;
            state_next             = ACCESS;
        end else begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inf_address    <= '0;
            inf_write_data <= '0;
            inf_funct3     <= '0;
            inf_rd         <= '0;
            inf_read       <= 1'b0;
            inf_write      <= 1'b0;
            inf_error      <= 1'b0;
        end else if (issue) begin
            inf_address    <= ex_address;
            inf_write_data <= ex_store_data;
            inf_funct3     <= ex_funct3;
            inf_rd         <= ex_rd;
            inf_read       <= issue_read;
            inf_write      <= issue_write;
            inf_error      <= ex_illegal;
        end
    end

    // WB result: valid pulses for one cycle, the payload holds until the next completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_error <= 1'b0;
        end else begin
            wb_valid <= complete;
            if (complete) begin
                wb_rd    <= inf_rd;
                wb_error <= inf_error;
                wb_we    <= inf_read && (inf_rd != RD_W'(0));
                wb_data  <= inf_read ? extend(inf_funct3, dmem.dmem_read_data) : '0;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: behavioural data memory plus a byte-array reference
// model of load/store results, directed steps followed by random traffic.
module tb_lsu_mem_stage;
    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_address, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_ready;
    logic        wb_valid, wb_we, wb_error;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    lsu_mem_stage_if dmem_bus ();

    lsu_mem_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ex_load       (ex_load),
        .ex_store      (ex_store),
        .ex_funct3     (ex_funct3),
        .ex_address    (ex_address),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_ready      (ex_ready),
        .dmem          (dmem_bus.master),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_error      (wb_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0]  init_mem [64];
    logic [7:0]  emem     [64];
    logic [7:0]  rmem     [64];
    logic        loaded = 1'b0;
    logic [31:0] emu_rdata;
    logic        emu_wait;

    assign dmem_bus.dmem_read_data = emu_rdata;
    assign dmem_bus.dmem_wait      = emu_wait;

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    // Behavioural memory: word-crossing accesses stall one cycle and complete
    // using the request as presented during the wait cycle.
    always @(posedge clk) begin : emu
        logic [31:0] v;
        logic [2:0]  m;
        int          sz;
        if (!loaded) begin
            for (int i = 0; i < 64; i++) emem[i] = init_mem[i];
            loaded = 1'b1;
        end
        m  = dmem_bus.dmem_read_enable ? dmem_bus.dmem_read_mode : dmem_bus.dmem_write_mode;
        sz = size_of(m);
        if (!reset_n) begin
            emu_wait  <= 1'b0;
            emu_rdata <= '0;
        end else if (emu_wait || (dmem_bus.dmem_enable &&
                     int'(dmem_bus.dmem_address[1:0]) + sz <= 4)) begin
            emu_wait <= 1'b0;
            v = '0;
            for (int j = 0; j < sz; j++) begin
                if (dmem_bus.dmem_write_enable)
                    emem[6'(dmem_bus.dmem_address + 32'(j))] = dmem_bus.dmem_write_data[8*j +: 8];
                v[8*j +: 8] = emem[6'(dmem_bus.dmem_address + 32'(j))];
            end
            emu_rdata <= dmem_bus.dmem_read_enable ? v : 32'h0;
        end else if (dmem_bus.dmem_enable) begin
            emu_wait  <= 1'b1;
            emu_rdata <= '0;
        end
    end

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          wait_cyc = -1;
    bit          post_reset = 1'b0;
    bit          accepted = 1'b0;
    exp_t        q[$];
    logic [31:0] wb_log[$];
    logic [31:0] cap_addr, cap_wdata;
    logic [2:0]  cap_mode;
    logic        cap_re, cap_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        chk(tag, 32'(obs), 32'(exp_v));
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] raw;
        raw = '0;
        for (int j = 0; j < size_of(f3); j++) raw[8*j +: 8] = rmem[6'(a + 32'(j))];
        if (f3 == 3'd0) return 32'($signed(raw[7:0]));
        if (f3 == 3'd1) return 32'($signed(raw[15:0]));
        return raw;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        for (int j = 0; j < size_of(f3); j++) rmem[6'(a + 32'(j))] = d[8*j +: 8];
    endtask

    // One clock: check outputs at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t        e;
        logic        exp_ready, legal, ld, wr, split;
        logic [31:0] d;
        @(negedge clk);
        accepted = 1'b0;
        if (!reset_n) begin
            chk1("rst_ex_ready", ex_ready, 1'b0);
            chk1("rst_enable", dmem_bus.dmem_enable, 1'b0);
            chk1("rst_read_enable", dmem_bus.dmem_read_enable, 1'b0);
            chk1("rst_write_enable", dmem_bus.dmem_write_enable, 1'b0);
            chk("rst_address", dmem_bus.dmem_address, 32'h0);
            q.delete();
            wait_cyc   = -1;
            post_reset = 1'b1;
        end else begin
            if (post_reset) begin
                chk("rst_wb_data", wb_data, 32'h0);
                chk("rst_wb_rd", 32'(wb_rd), 32'h0);
                chk1("rst_wb_we", wb_we, 1'b0);
                chk1("rst_wb_error", wb_error, 1'b0);
                post_reset = 1'b0;
            end
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk1("wb_valid", wb_valid, 1'b1);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk1("wb_we", wb_we, e.we);
                chk("wb_data", wb_data, e.data);
                chk1("wb_error", wb_error, e.err);
                wb_log.push_back(wb_data);
            end else begin
                chk1("wb_valid_quiet", wb_valid, 1'b0);
            end
            exp_ready = (cyc != wait_cyc);
            chk1("ex_ready", ex_ready, exp_ready);
            if (!exp_ready) begin
                chk1("wait_enable", dmem_bus.dmem_enable, 1'b1);
                chk("wait_address", dmem_bus.dmem_address, cap_addr);
                chk("wait_write_data", dmem_bus.dmem_write_data, cap_wdata);
                chk("wait_write_mode", 32'(dmem_bus.dmem_write_mode), 32'(cap_mode));
                chk("wait_read_mode", 32'(dmem_bus.dmem_read_mode), 32'(cap_mode));
                chk1("wait_read_enable", dmem_bus.dmem_read_enable, cap_re);
                chk1("wait_write_enable", dmem_bus.dmem_write_enable, cap_we);
            end else if (ex_valid && (ex_load || ex_store)) begin
                accepted = 1'b1;
                ld    = ex_load;
                wr    = ex_store && !ex_load;
                legal = (ex_funct3[1:0] != 2'd3);
                chk1("issue_enable", dmem_bus.dmem_enable, legal);
                chk1("issue_read_enable", dmem_bus.dmem_read_enable, legal && ld);
                chk1("issue_write_enable", dmem_bus.dmem_write_enable, legal && wr);
                if (legal) begin
                    chk("issue_address", dmem_bus.dmem_address, ex_address);
                    chk("issue_mode", 32'(dmem_bus.dmem_read_mode), 32'(ex_funct3));
                end
                if (legal && wr) chk("issue_write_data", dmem_bus.dmem_write_data, ex_store_data);
                split = legal && (int'(ex_address[1:0]) + size_of(ex_funct3) > 4);
                if (split) begin
                    wait_cyc  = cyc + 1;
                    cap_addr  = ex_address;
                    cap_wdata = ex_store_data;
                    cap_mode  = ex_funct3;
                    cap_re    = ld;
                    cap_we    = wr;
                end
                d = '0;
                if (legal && ld) d = ref_load(ex_address, ex_funct3);
                if (legal && wr) ref_store(ex_address, ex_funct3, ex_store_data);
                e.due  = cyc + (split ? 3 : 2);
                e.rd   = ex_rd;
                e.we   = legal && ld && (ex_rd != 5'd0);
                e.data = d;
                e.err  = !legal;
                q.push_back(e);
            end else begin
                chk1("no_request", dmem_bus.dmem_enable, 1'b0);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_load       = ld;
        ex_store      = st;
        ex_funct3     = f3;
        ex_address    = a;
        ex_store_data = d;
        ex_rd         = rd;
        accepted      = 1'b0;
        for (int k = 0; k < 8 && !accepted; k++) tick();
        chk1("op_accepted", accepted, 1'b1);
        ex_valid = 1'b0;
    endtask

    task automatic nop_op();
        ex_valid = 1'b1;
        ex_load  = 1'b0;
        ex_store = 1'b0;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin : stim
        logic [2:0]  lf3 [5];
        logic [2:0]  f3;
        logic [31:0] a, d;
        logic [4:0]  rd;
        logic        ld;
        int unsigned r;
        lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 64; i++) begin
            init_mem[i] = 8'($urandom);
            rmem[i]     = init_mem[i];
        end
        {init_mem[3], init_mem[2], init_mem[1], init_mem[0]} = 32'hDEADBEEF;
        {rmem[3], rmem[2], rmem[1], rmem[0]}                 = 32'hDEADBEEF;

        reset_n = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_funct3 = '0; ex_address = '0; ex_store_data = '0; ex_rd = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        wb_log.delete();
        op(1, 0, 3'd2, 32'h8000_0000, 0, 5'd1);
        idle(3);
        chk("lw_count", 32'(wb_log.size()), 32'd1);
        if (wb_log.size() >= 1) chk("lw_deadbeef", wb_log[0], 32'hDEADBEEF);

        wb_log.delete();
        op(0, 1, 3'd0, 32'h8000_0001, 32'h0000_0080, 5'd2);
        op(1, 0, 3'd0, 32'h8000_0001, 0, 5'd3);
        op(1, 0, 3'd4, 32'h8000_0001, 0, 5'd4);
        op(0, 1, 3'd1, 32'h8000_0008, 32'h0000_8001, 5'd0);
        op(1, 0, 3'd1, 32'h8000_0008, 0, 5'd6);
        idle(3);
        chk("ext_count", 32'(wb_log.size()), 32'd5);
        if (wb_log.size() >= 5) begin
            chk("lb_sign", wb_log[1], 32'hFFFF_FF80);
            chk("lbu_zero", wb_log[2], 32'h0000_0080);
            chk("lh_sign", wb_log[4], 32'hFFFF_8001);
        end

        op(1, 0, 3'd2, 32'h8000_0002, 0, 5'd7);
        op(1, 0, 3'd2, 32'h8000_0004, 0, 5'd8);
        idle(4);

        wb_log.delete();
        op(0, 1, 3'd2, 32'h8000_0003, 32'h1122_3344, 5'd9);
        op(1, 0, 3'd2, 32'h8000_0000, 0, 5'd10);
        op(1, 0, 3'd2, 32'h8000_0004, 0, 5'd11);
        idle(5);
        chk("sw_count", 32'(wb_log.size()), 32'd3);
        if (wb_log.size() >= 3) begin
            chk("sw_store_data", wb_log[0], 32'h0);
            chk("sw_low_word", 32'(wb_log[1][31:24]), 32'h44);
            chk("sw_high_word", 32'(wb_log[2][23:0]), 32'h112233);
        end

        op(1, 0, 3'd3, 32'h8000_0000, 0, 5'd5);
        idle(3);

        wb_log.delete();
        for (int k = 0; k < 4; k++) op(1, 0, 3'd2, 32'h8000_0010 + 32'(4 * k), 0, 5'(12 + k));
        idle(4);
        chk("b2b_count", 32'(wb_log.size()), 32'd4);

        op(1, 0, 3'd2, 32'h8000_0002, 0, 5'd13);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        idle(2);
        op(1, 0, 3'd2, 32'h8000_0000, 0, 5'd14);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 19);
            a  = 32'h8000_0000 | 32'($urandom_range(0, 63));
            d  = $urandom;
            rd = 5'($urandom_range(0, 31));
            if (r < 9) begin
                op(1, 0, lf3[$urandom_range(0, 4)], a, d, rd);
            end else if (r < 16) begin
                op(0, 1, 3'($urandom_range(0, 2)), a, d, rd);
            end else if (r == 16) begin
                op(1, 1, lf3[$urandom_range(0, 4)], a, d, rd);
            end else if (r == 17) begin
                nop_op();
            end else if (r == 18) begin
                idle(int'($urandom_range(1, 2)));
            end else begin
                ld = 1'($urandom_range(0, 1));
                f3 = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd7;
                op(ld, !ld, f3, a, d, rd);
            end
        end
        idle(6);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
